// File: rtl/rr_pkg.sv
// Shared constants and types for the round-robin request queue.
// Holds the default sizes, the statistics width and the requester-index type.
package rr_pkg;
  localparam int REQCNT_DEF = 4;
  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int STAT_W     = 16;

  typedef logic [$clog2(REQCNT_DEF)-1:0] req_idx_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rr_ch_fifo.sv
// Single-requester FIFO: registered count and pointers, head visible combinationally.
// The caller must never push when full or pop when empty.
module rr_ch_fifo #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push,
  input  logic [DWIDTH-1:0]      push_data,
  input  logic                   pop,
  output logic [DWIDTH-1:0]      head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/rr_req_queue.sv
// Per-requester FIFOs feeding one registered output chosen by an external arbiter grant.
// Optional head-of-line wait statistics are built only with RR_REQ_QUEUE_STAT_EN defined.
module rr_req_queue
  import rr_pkg::*;
#(
  parameter int REQCNT = REQCNT_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [REQCNT-1:0][DWIDTH-1:0]    wr_data_i,
  input  logic [REQCNT-1:0]                wr_val_i,
  output logic [REQCNT-1:0]                wr_rdy_o,
  output logic [REQCNT-1:0]                req_o,
  output logic                             req_val_o,
  input  logic [$clog2(REQCNT)-1:0]        req_num_i,
  output logic [DWIDTH-1:0]                rd_data_o,
  output logic [$clog2(REQCNT)-1:0]        rd_num_o,
  output logic                             rd_val_o,
  input  logic                             rd_rdy_i,
  output logic [STAT_W-1:0]                stat_max_wait_o
);
  localparam int IW = $clog2(REQCNT);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count [REQCNT];
  logic [DWIDTH-1:0] head  [REQCNT];
  logic [REQCNT-1:0] push;
  logic [REQCNT-1:0] pop;
  logic              out_free;
  logic              pop_any;
  logic [DWIDTH-1:0] head_sel;

  for (genvar g = 0; g < REQCNT; g++) begin : g_ch
    assign wr_rdy_o[g] = (count[g] != CW'(DEPTH));
    assign req_o[g]    = (count[g] != '0);
    assign push[g]     = wr_val_i[g] && wr_rdy_o[g];

    rr_ch_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .push      (push[g]),
      .push_data (wr_data_i[g]),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g])
    );
  end

  assign req_val_o = |req_o;
  assign out_free  = !rd_val_o || rd_rdy_i;
  assign pop_any   = |pop;

  // A grant onto an empty FIFO simply produces no pop.
  always_comb begin
    pop      = '0;
    head_sel = '0;
    for (int i = 0; i < REQCNT; i++) begin
      if (req_num_i == IW'(i)) begin
        pop[i]   = out_free && req_val_o && req_o[i];
        head_sel = head[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= '0;
      rd_num_o  <= '0;
      rd_val_o  <= 1'b0;
    end else if (pop_any) begin
      rd_data_o <= head_sel;
      rd_num_o  <= req_num_i;
      rd_val_o  <= 1'b1;
    end else if (out_free) begin
      rd_val_o  <= 1'b0;
    end
  end

`ifdef RR_REQ_QUEUE_STAT_EN
  logic [STAT_W-1:0] wait_cnt [REQCNT];
  logic [STAT_W-1:0] cur_max;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REQCNT; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REQCNT; i++) begin
        if (!req_o[i] || pop[i]) wait_cnt[i] <= '0;
        else                     wait_cnt[i] <= sat_inc(wait_cnt[i]);
      end
    end
  end

  always_comb begin
    cur_max = '0;
    for (int i = 0; i < REQCNT; i++) begin
      if (wait_cnt[i] > cur_max) cur_max = wait_cnt[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      stat_max_wait_o <= '0;
    else if (cur_max > stat_max_wait_o) stat_max_wait_o <= cur_max;
  end
`else
  assign stat_max_wait_o = '0;
`endif
endmodule

// File: tb/tb_rr_req_queue.sv
// Directed bench for rr_req_queue: latency, full FIFO, stall, empty grant, reset, wait statistics.
module tb_rr_req_queue;
  import rr_pkg::*;

  logic            clk_i;
  logic            rst_n_i;
  logic [3:0][7:0] wr_data_i;
  logic [3:0]      wr_val_i;
  logic [3:0]      wr_rdy_o;
  logic [3:0]      req_o;
  logic            req_val_o;
  req_idx_t        req_num_i;
  logic [7:0]      rd_data_o;
  logic [1:0]      rd_num_o;
  logic            rd_val_o;
  logic            rd_rdy_i;
  logic [15:0]     stat_max_wait_o;

  int n_chk  = 0;
  int n_pass = 0;

  rr_req_queue dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .wr_data_i       (wr_data_i),
    .wr_val_i        (wr_val_i),
    .wr_rdy_o        (wr_rdy_o),
    .req_o           (req_o),
    .req_val_o       (req_val_o),
    .req_num_i       (req_num_i),
    .rd_data_o       (rd_data_o),
    .rd_num_o        (rd_num_o),
    .rd_val_o        (rd_val_o),
    .rd_rdy_i        (rd_rdy_i),
    .stat_max_wait_o (stat_max_wait_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i   = 1'b0;
    wr_val_i  = '0;
    wr_data_i = '0;
    req_num_i = '0;
    rd_rdy_i  = 1'b1;

    #7;
    chk("rst_rd_val",  rd_val_o,  0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_num",  rd_num_o,  0);
    chk("rst_req",     req_o,     0);
    chk("rst_req_val", req_val_o, 0);
    chk("rst_wr_rdy",  wr_rdy_o,  4'hF);
    chk("rst_stat",    stat_max_wait_o, 0);
    #5 rst_n_i = 1'b1;
    step();

    // Single word through requester 2.
    req_num_i = 2'd2;
    wr_val_i  = 4'b0100;
    wr_data_i[2] = 8'hA5;
    step();
    chk("s1_req_p1", req_o, 4'b0100);
    chk("s1_val_p1", rd_val_o, 0);
    wr_val_i = '0;
    step();
    chk("s1_val_p2",  rd_val_o,  1);
    chk("s1_data_p2", rd_data_o, 8'hA5);
    chk("s1_num_p2",  rd_num_o,  2);
    step();
    chk("s1_req_p3", req_o, 0);
    chk("s1_val_p3", rd_val_o, 0);

    // Fill requester 0 past full while the grant points at an empty FIFO.
    req_num_i = 2'd3;
    wr_val_i  = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      wr_data_i[0] = 8'(i);
      step();
      if (i == 4) chk("s2_wr_rdy_full", wr_rdy_o[0], 0);
    end
    chk("s2_req_full", req_o, 4'b0001);
    chk("s2_val_idle", rd_val_o, 0);
    wr_val_i  = '0;
    req_num_i = 2'd0;
    step();
    chk("s2_data_1", rd_data_o, 1);
    chk("s2_num_1",  rd_num_o,  0);
    chk("s2_val_1",  rd_val_o,  1);

    // Stall the output for 5 cycles.
    rd_rdy_i = 1'b0;
    repeat (5) begin
      step();
      chk("s3_hold_data", rd_data_o, 1);
      chk("s3_hold_num",  rd_num_o,  0);
      chk("s3_hold_val",  rd_val_o,  1);
      chk("s3_hold_rdy",  wr_rdy_o[0], 1);
    end
    rd_rdy_i = 1'b1;
    for (int v = 2; v <= 4; v++) begin
      step();
      chk("s2_data_seq", rd_data_o, 32'(v));
      chk("s2_val_seq",  rd_val_o,  1);
    end
    step();
    chk("s2_val_drain", rd_val_o, 0);
    chk("s2_req_drain", req_o, 0);
`ifndef RR_REQ_QUEUE_STAT_EN
    chk("s2_stat_off", stat_max_wait_o, 0);
`endif

    // Grant pointing at an empty FIFO.
    req_num_i = 2'd3;
    rd_rdy_i  = 1'b0;
    wr_val_i  = 4'b0010;
    wr_data_i[1] = 8'h11;
    step();
    wr_data_i[1] = 8'h22;
    step();
    wr_val_i  = '0;
    req_num_i = 2'd1;
    step();
    chk("s4_val",  rd_val_o,  1);
    chk("s4_data", rd_data_o, 8'h11);
    chk("s4_num",  rd_num_o,  1);
    chk("s4_req",  req_o, 4'b0010);
    req_num_i = 2'd3;
    rd_rdy_i  = 1'b1;
    step();
    chk("s4_val_drop", rd_val_o,  0);
    chk("s4_req_keep", req_o, 4'b0010);
    chk("s4_data_keep", rd_data_o, 8'h11);
    step();
    chk("s4_val_idle", rd_val_o, 0);
    chk("s4_req_idle", req_o, 4'b0010);
`ifndef RR_REQ_QUEUE_STAT_EN
    chk("s4_stat_off", stat_max_wait_o, 0);
`endif

    // Reset pulse mid-stream with 3 words queued in requester 2.
    wr_val_i = 4'b0100;
    wr_data_i[2] = 8'h33; step();
    wr_data_i[2] = 8'h44; step();
    wr_data_i[2] = 8'h55; step();
    wr_val_i = '0;
    chk("s5_req_q", req_o, 4'b0110);
    req_num_i = 2'd1;
    rd_rdy_i  = 1'b0;
    step();
    chk("s5_val_pre",  rd_val_o,  1);
    chk("s5_data_pre", rd_data_o, 8'h22);
    rst_n_i = 1'b0;
    #1;
    chk("s5_rst_val",  rd_val_o,  0);
    chk("s5_rst_data", rd_data_o, 0);
    chk("s5_rst_num",  rd_num_o,  0);
    chk("s5_rst_req",  req_o,     0);
    chk("s5_rst_rv",   req_val_o, 0);
    chk("s5_rst_rdy",  wr_rdy_o,  4'hF);
    chk("s5_rst_stat", stat_max_wait_o, 0);
    rst_n_i   = 1'b1;
    req_num_i = 2'd2;
    rd_rdy_i  = 1'b1;
    step();
    step();
    chk("s5_post_req", req_o, 0);
    chk("s5_post_val", rd_val_o, 0);
    chk("s5_post_rdy", wr_rdy_o, 4'hF);

    // Requester 1 waits 6 cycles before its grant.
    req_num_i = 2'd0;
    wr_val_i  = 4'b0010;
    wr_data_i[1] = 8'h66;
    step();
    wr_val_i = '0;
    chk("s6_req", req_o, 4'b0010);
    repeat (6) step();
    req_num_i = 2'd1;
    step();
    chk("s6_val",  rd_val_o,  1);
    chk("s6_data", rd_data_o, 8'h66);
    chk("s6_num",  rd_num_o,  1);
    step();
`ifdef RR_REQ_QUEUE_STAT_EN
    chk("s6_stat", stat_max_wait_o, 6);
`else
    chk("s6_stat", stat_max_wait_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
